// File: rtl/victim_cache_buffer.sv
// Victim cache buffer: FIFO of evicted lines with youngest-match label lookup
// and byte-masked in-place update of a matching entry.
module victim_cache_buffer #(
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned LINE_DEPTH = 8,
  localparam int unsigned LINE_BYTES = LINE_WIDTH / 8,
  localparam int unsigned LINE_BYTE_OFFSET = $clog2(LINE_BYTES),
  localparam int unsigned LABEL_WIDTH = 32 - LINE_BYTE_OFFSET,
  localparam int unsigned ADDR_WIDTH = $clog2(LINE_DEPTH),
  localparam int unsigned ENTRY_WIDTH = LABEL_WIDTH + LINE_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [ENTRY_WIDTH-1:0] pline,
  output logic                   pushed,
  input  logic                   pop,
  output logic [ENTRY_WIDTH-1:0] rline,
  output logic                   full,
  output logic                   empty,
  input  logic [LABEL_WIDTH-1:0] query_label,
  output logic                   query_found,
  output logic [LINE_WIDTH-1:0]  query_rdata,
  input  logic                   write,
  input  logic [LINE_WIDTH-1:0]  query_wdata,
  input  logic [LINE_BYTES-1:0]  query_wbe,
  output logic                   written
);

  localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

  logic [LABEL_WIDTH-1:0] label_q [LINE_DEPTH];
  logic [LINE_WIDTH-1:0]  data_q  [LINE_DEPTH];
  logic [LINE_DEPTH-1:0]  valid_q;
  logic [ADDR_WIDTH-1:0]  head_q;
  logic [ADDR_WIDTH-1:0]  tail_q;
  logic [CNT_WIDTH-1:0]   count_q;

  logic                   do_push;
  logic                   do_pop;
  logic                   hit;
  logic [ADDR_WIDTH-1:0]  hit_idx;
  logic [ADDR_WIDTH-1:0]  scan_idx;
  logic [LINE_WIDTH-1:0]  merged;

  assign full    = (count_q == CNT_WIDTH'(LINE_DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | pop);
  assign pushed  = do_push;
  assign rline   = empty ? '0 : {label_q[head_q], data_q[head_q]};

  // Scan oldest to youngest so the youngest matching entry wins
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    scan_idx = '0;
    for (int unsigned i = 0; i < LINE_DEPTH; i++) begin
      scan_idx = head_q + ADDR_WIDTH'(i);
      if (valid_q[scan_idx] && (label_q[scan_idx] == query_label)) begin
        hit     = 1'b1;
        hit_idx = scan_idx;
      end
    end
  end

  assign query_found = hit;
  assign query_rdata = hit ? data_q[hit_idx] : '0;
  assign written     = write & hit;

  always_comb begin
    merged = data_q[hit_idx];
    for (int unsigned b = 0; b < LINE_BYTES; b++) begin
      if (query_wbe[b]) merged[8*b +: 8] = query_wdata[8*b +: 8];
    end
  end

  // Write lands first; a same-cycle pop of that entry invalidates it anyway,
  // and a push can only target the slot being freed, so it overrides last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int unsigned i = 0; i < LINE_DEPTH; i++) begin
        label_q[i] <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      if (written) data_q[hit_idx] <= merged;
      if (do_pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + ADDR_WIDTH'(1);
      end
      if (do_push) begin
        label_q[tail_q] <= pline[ENTRY_WIDTH-1:LINE_WIDTH];
        data_q[tail_q]  <= pline[LINE_WIDTH-1:0];
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + ADDR_WIDTH'(1);
      end
      count_q <= count_q + CNT_WIDTH'(do_push) - CNT_WIDTH'(do_pop);
    end
  end

endmodule

// File: tb/tb_victim_cache_buffer.sv
// Scoreboard bench for victim_cache_buffer: a queue model predicts per-cycle
// handshake/query outputs and the post-edge head/status view.
module tb_victim_cache_buffer;

  localparam int unsigned LW = 256;
  localparam int unsigned NB = LW / 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LBW = 27;
  localparam int unsigned EW = LBW + LW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          push = 1'b0;
  logic [EW-1:0] pline = '0;
  logic          pushed;
  logic          pop = 1'b0;
  logic [EW-1:0] rline;
  logic          full;
  logic          empty;
  logic [LBW-1:0] query_label = '0;
  logic          query_found;
  logic [LW-1:0] query_rdata;
  logic          write = 1'b0;
  logic [LW-1:0] query_wdata = '0;
  logic [NB-1:0] query_wbe = '0;
  logic          written;

  victim_cache_buffer dut (
    .clk(clk), .rst(rst), .push(push), .pline(pline), .pushed(pushed),
    .pop(pop), .rline(rline), .full(full), .empty(empty),
    .query_label(query_label), .query_found(query_found), .query_rdata(query_rdata),
    .write(write), .query_wdata(query_wdata), .query_wbe(query_wbe), .written(written)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [EW-1:0] rline;
    logic          full;
    logic          empty;
  } exp_t;

  exp_t          sb[$];
  logic [EW-1:0] mdl[$];
  int            n_vec = 0;
  int            n_bad = 0;

  task automatic chk(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] mkline(input logic [LBW-1:0] lbl, input logic [7:0] fill);
    logic [LW-1:0] d;
    for (int b = 0; b < int'(NB); b++) d[8*b +: 8] = fill;
    return {lbl, d};
  endfunction

  task automatic check_state();
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("rline", rline, e.rline);
      chk("full", EW'(full), EW'(e.full));
      chk("empty", EW'(empty), EW'(e.empty));
    end
  endtask

  // One request cycle: sample previous result, drive, check combinational outputs, advance model
  task automatic step(input logic p, input logic [EW-1:0] pl, input logic q,
                      input logic [LBW-1:0] ql, input logic w,
                      input logic [LW-1:0] wd, input logic [NB-1:0] wbe);
    logic          e_push;
    logic          e_found;
    int            e_idx;
    logic [LW-1:0] e_data;
    exp_t          e;
    @(negedge clk);
    check_state();
    push = p; pline = pl; pop = q; query_label = ql;
    write = w; query_wdata = wd; query_wbe = wbe;
    #1;
    e_push  = p & ((mdl.size() < int'(DEPTH)) | q);
    e_found = 1'b0;
    e_idx   = 0;
    for (int i = 0; i < mdl.size(); i++) begin
      if (mdl[i][EW-1:LW] == ql) begin
        e_found = 1'b1;
        e_idx   = i;
      end
    end
    e_data = e_found ? mdl[e_idx][LW-1:0] : '0;
    chk("pushed", EW'(pushed), EW'(e_push));
    chk("query_found", EW'(query_found), EW'(e_found));
    chk("query_rdata", EW'(query_rdata), EW'(e_data));
    chk("written", EW'(written), EW'(w & e_found));
    if (w && e_found) begin
      for (int b = 0; b < int'(NB); b++)
        if (wbe[b]) e_data[8*b +: 8] = wd[8*b +: 8];
      mdl[e_idx][LW-1:0] = e_data;
    end
    if (q && mdl.size() != 0) void'(mdl.pop_front());
    if (e_push) mdl.push_back(pl);
    e.rline = (mdl.size() != 0) ? mdl[0] : '0;
    e.full  = (mdl.size() == int'(DEPTH));
    e.empty = (mdl.size() == 0);
    sb.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    push = 1'b0; pop = 1'b0; write = 1'b0;
    #1;
    chk("rst_empty", EW'(empty), EW'(1'b1));
    chk("rst_full", EW'(full), EW'(1'b0));
    chk("rst_rline", rline, '0);
    mdl.delete();
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [LW-1:0] ones;

  initial begin
    ones = '1;
    #12;
    chk("init_empty", EW'(empty), EW'(1'b1));
    chk("init_rline", rline, '0);
    chk("init_pushed", EW'(pushed), EW'(1'b0));
    @(negedge clk);
    rst = 1'b1;

    // Fill with labels 1..8, then an overflow push
    for (int k = 1; k <= 8; k++) step(1'b1, mkline(LBW'(k), 8'(8'h11 * k)), 1'b0, LBW'(k), 1'b0, '0, '0);
    step(1'b1, mkline(LBW'(32), 8'hEE), 1'b0, LBW'(1), 1'b0, '0, '0);
    // Byte-masked write to label 3, and to an absent label
    step(1'b0, '0, 1'b0, LBW'(3), 1'b1, ones, NB'(32'h0000000F));
    step(1'b0, '0, 1'b0, LBW'(27'h7FFFFFF), 1'b1, ones, '1);
    step(1'b0, '0, 1'b0, LBW'(3), 1'b0, '0, '0);
    // Push+pop while full
    step(1'b1, mkline(LBW'(9), 8'h99), 1'b1, LBW'(9), 1'b0, '0, '0);
    for (int k = 0; k < 8; k++) step(1'b0, '0, 1'b1, LBW'(k + 2), 1'b0, '0, '0);
    // Pop on empty, then push+pop on empty
    step(1'b0, '0, 1'b1, LBW'(2), 1'b0, '0, '0);
    step(1'b1, mkline(LBW'(10), 8'hAA), 1'b1, LBW'(10), 1'b0, '0, '0);
    // Duplicate label: youngest match wins; write to head lost by same-cycle pop
    step(1'b1, mkline(LBW'(5), 8'h51), 1'b0, LBW'(5), 1'b0, '0, '0);
    step(1'b1, mkline(LBW'(5), 8'h52), 1'b0, LBW'(5), 1'b0, '0, '0);
    step(1'b0, '0, 1'b0, LBW'(5), 1'b1, ones, NB'(32'hF0F0F0F0));
    step(1'b0, '0, 1'b1, LBW'(10), 1'b1, ones, '1);
    step(1'b0, '0, 1'b0, LBW'(10), 1'b0, '0, '0);
    for (int k = 0; k < 6; k++)
      step(1'b1, mkline(LBW'($urandom_range(1, 6)), 8'($urandom)), 1'($urandom),
           LBW'($urandom_range(1, 6)), 1'($urandom), {8{$urandom}}, NB'($urandom));
    idle();
    @(negedge clk);
    check_state();
    do_reset();
    step(1'b1, mkline(LBW'(12), 8'hC3), 1'b0, LBW'(12), 1'b0, '0, '0);
    idle();
    @(negedge clk);
    check_state();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/victim_cache_buffer.md
Name: victim_cache_buffer

Overview:
- Small fully-associative FIFO of evicted cache lines, sitting beside a L1 cache.
- Each entry holds a label (physical line address) and a line of data.
- Lines are pushed on eviction and popped in FIFO order for write-back.
- Entries can be looked up by label and partially overwritten with byte enables.

Parameters:
- LINE_WIDTH, 256: data bits per line; must be a multiple of 8.
- LINE_DEPTH, 8: number of entries; power of two and at least 2.
- LINE_BYTE_OFFSET, derived: log2(LINE_WIDTH/8), 5 at the defaults.
- LABEL_WIDTH, derived: 32 - LINE_BYTE_OFFSET (physical address is 32 bits), 27 at the defaults.
- ADDR_WIDTH, derived: log2(LINE_DEPTH).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- push  in  1  request to append pline.
- pline  in  LABEL_WIDTH+LINE_WIDTH  line to push; label in the MSBs {label, data}.
- pushed  out  1  push accepted this cycle.
- pop  in  1  request to remove the head entry.
- rline  out  LABEL_WIDTH+LINE_WIDTH  head (oldest) entry {label, data}.
- full  out  1  LINE_DEPTH entries valid.
- empty  out  1  no entries valid.
- query_label  in  LABEL_WIDTH  label to look up or write.
- query_found  out  1  a valid entry matches query_label.
- query_rdata  out  LINE_WIDTH  data of the matching entry; 0 if no match.
- write  in  1  byte-masked write to the matching entry.
- query_wdata  in  LINE_WIDTH  write data.
- query_wbe  in  LINE_WIDTH/8  byte enables; bit i covers data bits [8i+7:8i].
- written  out  1  write performed this cycle.

Behaviour:
- Reset (rst=0, async):
  - head and tail pointers cleared, count=0.
  - All entry storage cleared to 0 and all valid bits cleared.
  - Outputs: empty=1, full=0, rline=0, pushed=0, written=0, query_found=0, query_rdata=0.
- Storage and status:
  - Circular buffer with head/tail pointers of ADDR_WIDTH bits and a count of ADDR_WIDTH+1 bits.
  - full = (count==LINE_DEPTH); empty = (count==0).
- rline: combinational view of the entry at head; all zeros when empty.
- Push:
  - pushed = push & (~full | pop), combinational.
  - On a clock edge with pushed=1: mem[tail] <= pline, valid set, tail increments with wrap.
  - Push while full without pop is dropped (pushed=0); state is unchanged.
- Pop:
  - When pop=1 and not empty: the head entry's valid bit clears and head increments with wrap.
  - Pop on an empty buffer is ignored.
- Simultaneous push and pop ("pp"):
  - Not empty: both occur and count is unchanged. When full, the new line occupies the slot freed by the pop.
  - Empty: only the push occurs, and count becomes 1.
- Query (combinational):
  - Compare query_label against all valid entries.
  - Multiple matches: the youngest entry (closest to tail) wins.
  - A line pushed in the current cycle is not visible until the next cycle.
- Write:
  - written = write & query_found, combinational.
  - On the edge, the matched entry's data bytes with query_wbe[i]=1 take query_wdata; other bytes and the label are kept.
  - write with no match does nothing.
  - If the matched entry is popped in the same cycle, the write is lost with it.
  - Independent of push/pop otherwise; all three may occur in one cycle.
- Counters wrap modulo LINE_DEPTH; count never exceeds LINE_DEPTH or goes below 0.
- Reset asserted mid-operation discards all entries immediately.
- Bench timing: requests are applied at the falling edge; outputs are sampled at the next falling edge, after the state has updated on the rising edge.

Test Plan:
- Reset, then push label 0x0000001, data 0x11…11 → next cycle: rline=0000001-11…11, empty=0, pushed was 1.
- Push 8 distinct lines (labels 1..8) → full=1; a 9th push gives pushed=0 and rline remains label 1.
- While full, "pp" with label 9 → rline=label 2, full stays 1, count 8; eight further pops return labels 2..9 in order, then empty=1 and rline=0.
- Write query_label=3, query_wbe=0x0000000F, query_wdata=0xFF…FF → written=1; entry 3 then has low 4 bytes 0xFF and the rest unchanged, visible in rline when it reaches head.
- Write to absent label 0x7FFFFFF → written=0 and no entry changes; pop on empty → no change, empty=1.
- "pp" on empty with label 0xA → rline=label 0xA, count 1; assert rst mid-sequence → empty=1 and rline=0 immediately.
